// File: rtl/lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : lockstep_checker
// Purpose  : Compares a delayed side-A bus against side B per channel and
//            escalates persistent mismatches (OK -> SUSPECT -> sticky FAULT).
//            Define LOCKSTEP_CAPTURE_EN to latch the faulting channel values.
// Revision : 1.0
// ============================================================================
module lockstep_checker #(
  parameter int W      = 8,
  parameter int N      = 2,
  parameter int DLY    = 0,
  parameter int THRESH = 1,
  parameter int CW     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N*W-1:0]                     a_i,
  input  logic [N*W-1:0]                     b_i,
  input  logic                               valid_i,
  input  logic                               clear_i,
  output logic [N-1:0]                       mismatch_o,
  output logic [1:0]                         state_o,
  output logic                               fault_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] fault_ch_o,
  output logic [CW-1:0]                      err_cnt_o,
  output logic [W-1:0]                       cap_a_o,
  output logic [W-1:0]                       cap_b_o
);

  localparam int CHW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FAULT   = 2'b10
  } state_t;

  state_t         state_q;
  logic [7:0]     run_q;
  logic [7:0]     run_inc;
  logic [CHW-1:0] fch_q;
  logic [CW-1:0]  err_q, err_d;
  logic [N-1:0]   mis_q, mis_d;
  logic [3:0]     warm_q;
  logic           warm, cmp, any_mis, enter_fault;
  logic [N-1:0]   diff;
  logic [CHW-1:0] low_ch;
  logic [N*W-1:0] a_dly;

  generate
    if (DLY == 0) begin : g_nodly
      assign a_dly = a_i;
    end else begin : g_dly
      logic [N*W-1:0] line_q [DLY];
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int s = 0; s < DLY; s++) line_q[s] <= '0;
        end else begin
          line_q[0] <= a_i;
          for (int s = 1; s < DLY; s++) line_q[s] <= line_q[s-1];
        end
      end
      assign a_dly = line_q[DLY-1];
    end
  endgenerate

  // Warm-up: compares stay suppressed until the delay line holds post-reset data.
  assign warm = (warm_q == 4'(DLY));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     warm_q <= '0;
    else if (!warm) warm_q <= warm_q + 4'd1;
  end

  always_comb begin
    diff   = '0;
    low_ch = '0;
    for (int k = 0; k < N; k++) diff[k] = (a_dly[k*W +: W] != b_i[k*W +: W]);
    for (int k = N - 1; k >= 0; k--) if (diff[k]) low_ch = CHW'(k);
  end

  assign cmp         = valid_i & ~clear_i & warm;
  assign any_mis     = |diff;
  assign run_inc     = run_q + 8'd1;
  assign enter_fault = cmp & any_mis &
                       (((state_q == ST_OK) && (THRESH == 1)) ||
                        ((state_q == ST_SUSPECT) && (run_inc >= 8'(THRESH))));
  assign mis_d       = cmp ? diff : '0;
  assign err_d       = (cmp && any_mis && !(&err_q)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_OK;
      run_q   <= '0;
      fch_q   <= '0;
      err_q   <= '0;
      mis_q   <= '0;
    end else if (clear_i) begin
      state_q <= ST_OK;
      run_q   <= '0;
      fch_q   <= '0;
      err_q   <= '0;
      mis_q   <= '0;
    end else begin
      err_q <= err_d;
      mis_q <= mis_d;
      if (enter_fault) begin
        state_q <= ST_FAULT;
        run_q   <= run_inc;
        fch_q   <= low_ch;
      end else if (cmp) begin
        case (state_q)
          ST_OK: begin
            if (any_mis) begin
              state_q <= ST_SUSPECT;
              run_q   <= 8'd1;
            end
          end
          ST_SUSPECT: begin
            if (any_mis) begin
              run_q <= run_inc;
            end else begin
              state_q <= ST_OK;
              run_q   <= '0;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

`ifdef LOCKSTEP_CAPTURE_EN
  logic [W-1:0] cap_a_q, cap_b_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i || clear_i) begin
      cap_a_q <= '0;
      cap_b_q <= '0;
    end else if (enter_fault) begin
      cap_a_q <= a_dly[int'(low_ch)*W +: W];
      cap_b_q <= b_i[int'(low_ch)*W +: W];
    end
  end

  assign cap_a_o = cap_a_q;
  assign cap_b_o = cap_b_q;
`else
  assign cap_a_o = '0;
  assign cap_b_o = '0;
`endif

  assign mismatch_o = mis_q;
  assign state_o    = state_q;
  assign fault_o    = (state_q == ST_FAULT);
  assign fault_ch_o = fch_q;
  assign err_cnt_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockstep_checker
// Purpose  : Self-checking bench for lockstep_checker (THRESH=3 and THRESH=1
//            instances on shared stimulus) against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_lockstep_checker;

  localparam int TDLY = 2;

`ifdef LOCKSTEP_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] a_i, b_i;
  logic        valid_i, clear_i;

  logic [1:0] mis_o  [2];
  logic [1:0] st_o   [2];
  logic       flt_o  [2];
  logic       fch_o  [2];
  logic [3:0] err_o  [2];
  logic [7:0] capa_o [2];
  logic [7:0] capb_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lockstep_checker #(.W(8), .N(2), .DLY(TDLY), .THRESH(3), .CW(4)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
    .clear_i(clear_i), .mismatch_o(mis_o[0]), .state_o(st_o[0]), .fault_o(flt_o[0]),
    .fault_ch_o(fch_o[0]), .err_cnt_o(err_o[0]), .cap_a_o(capa_o[0]), .cap_b_o(capb_o[0])
  );

  lockstep_checker #(.W(8), .N(2), .DLY(TDLY), .THRESH(1), .CW(4)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
    .clear_i(clear_i), .mismatch_o(mis_o[1]), .state_o(st_o[1]), .fault_o(flt_o[1]),
    .fault_ch_o(fch_o[1]), .err_cnt_o(err_o[1]), .cap_a_o(capa_o[1]), .cap_b_o(capb_o[1])
  );

  // Reference model: history of side-A samples plus per-instance escalation state.
  logic [15:0] hist [TDLY];
  int          since;
  logic [1:0]  mis_m;
  int          st_m [2];
  int          run_m [2];
  int          err_m [2];
  int          fch_m [2];
  logic [7:0]  capa_m [2];
  logic [7:0]  capb_m [2];

  function automatic int th_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < TDLY; s++) hist[s] = '0;
    since = 0;
    mis_m = '0;
    for (int i = 0; i < 2; i++) begin
      st_m[i] = 0; run_m[i] = 0; err_m[i] = 0; fch_m[i] = 0;
      capa_m[i] = '0; capb_m[i] = '0;
    end
  endfunction

  function automatic void model_step(input logic v, input logic c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ad;
    logic [1:0]  d;
    logic        cmp;
    bit          enter;
    int          low;
    ad  = hist[TDLY-1];
    cmp = v && !c && (since >= TDLY);
    for (int k = 0; k < 2; k++) d[k] = (ad[k*8 +: 8] != b[k*8 +: 8]);
    low = 0;
    for (int k = 0; k < 2; k++) if (d[k]) begin low = k; break; end
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        st_m[i] = 0; run_m[i] = 0; err_m[i] = 0; fch_m[i] = 0;
        capa_m[i] = '0; capb_m[i] = '0;
      end else if (cmp && d != 2'b00) begin
        err_m[i] = (err_m[i] < 15) ? err_m[i] + 1 : 15;
        enter = 0;
        if (st_m[i] == 0) begin
          if (th_of(i) == 1) enter = 1;
          else begin st_m[i] = 1; run_m[i] = 1; end
        end else if (st_m[i] == 1) begin
          run_m[i] = run_m[i] + 1;
          if (run_m[i] >= th_of(i)) enter = 1;
        end
        if (enter) begin
          st_m[i]  = 2;
          fch_m[i] = low;
          if (CAP_EN) begin
            capa_m[i] = ad[low*8 +: 8];
            capb_m[i] = b[low*8 +: 8];
          end
        end
      end else if (cmp && st_m[i] == 1) begin
        st_m[i] = 0; run_m[i] = 0;
      end
    end
    mis_m = cmp ? d : 2'b00;
    for (int s = TDLY - 1; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = a;
    if (since < 1000) since++;
  endfunction

  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    valid_i = v; a_i = a; b_i = b; clear_i = c;
    @(posedge clk_i);
    model_step(v, c, a, b);
    @(negedge clk_i);
  endtask

  // Two clear cycles load a known value into the delay line and reset state.
  task automatic prime(input logic [15:0] a);
    step(1'b0, a, a, 1'b1);
    step(1'b0, a, a, 1'b1);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0; a_i = '0; b_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      checks++; if (st_o[i] !== 2'b00) begin errors++; $display("FAIL reset_state[%0d]: got %0d want 0", i, st_o[i]); end
      checks++; if (err_o[i] !== 4'd0) begin errors++; $display("FAIL reset_err[%0d]: got %0d want 0", i, err_o[i]); end
      checks++; if (mis_o[i] !== 2'b00 || flt_o[i] !== 1'b0 || fch_o[i] !== 1'b0) begin
        errors++; $display("FAIL reset_flags[%0d]: got mis=%b flt=%b fch=%b want 0", i, mis_o[i], flt_o[i], fch_o[i]); end
      checks++; if (capa_o[i] !== 8'h00 || capb_o[i] !== 8'h00) begin
        errors++; $display("FAIL reset_cap[%0d]: got %h/%h want 00/00", i, capa_o[i], capb_o[i]); end
    end
    rst_i = 1'b1;
  endtask

  task automatic test_match_stream();
    logic [15:0] a;
    for (int n = 0; n < 50; n++) begin
      a = 16'($urandom);
      step(1'b1, a, hist[TDLY-1], 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (st_o[i] !== 2'b00 || err_o[i] !== 4'd0 || mis_o[i] !== 2'b00) begin
          errors++; $display("FAIL match_stream[%0d] cyc %0d: got st=%0d err=%0d mis=%b want 0/0/00", i, n, st_o[i], err_o[i], mis_o[i]);
        end
      end
    end
  endtask

  task automatic test_suspect_recover();
    prime(16'h553C);
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    checks++; if (st_o[0] !== 2'b01) begin errors++; $display("FAIL suspect_enter: got %0d want 1", st_o[0]); end
    checks++; if (mis_o[0] !== 2'b10) begin errors++; $display("FAIL suspect_mis: got %b want 10", mis_o[0]); end
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    checks++; if (st_o[0] !== 2'b01) begin errors++; $display("FAIL suspect_hold: got %0d want 1", st_o[0]); end
    step(1'b1, 16'h553C, 16'h553C, 1'b0);
    checks++; if (st_o[0] !== 2'b00 || flt_o[0] !== 1'b0) begin
      errors++; $display("FAIL suspect_recover: got st=%0d flt=%b want 0/0", st_o[0], flt_o[0]); end
    checks++; if (err_o[0] !== 4'd2) begin errors++; $display("FAIL suspect_err: got %0d want 2", err_o[0]); end
    checks++; if (st_o[1] !== 2'(st_m[1]) || fch_o[1] !== 1'(fch_m[1])) begin
      errors++; $display("FAIL suspect_thr1: got st=%0d fch=%0d want %0d/%0d", st_o[1], fch_o[1], st_m[1], fch_m[1]); end
  endtask

  task automatic test_fault_gaps();
    prime(16'h553C);
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    step(1'b0, 16'h553C, 16'h0000, 1'b0);
    checks++; if (st_o[0] !== 2'b01 || mis_o[0] !== 2'b00) begin
      errors++; $display("FAIL gap_hold: got st=%0d mis=%b want 1/00", st_o[0], mis_o[0]); end
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    step(1'b0, 16'h553C, 16'h0000, 1'b0);
    checks++; if (st_o[0] !== 2'b01) begin errors++; $display("FAIL gap_hold2: got %0d want 1", st_o[0]); end
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    checks++; if (st_o[0] !== 2'b10 || flt_o[0] !== 1'b1) begin
      errors++; $display("FAIL gap_fault: got st=%0d flt=%b want 2/1", st_o[0], flt_o[0]); end
    checks++; if (fch_o[0] !== 1'b1) begin errors++; $display("FAIL gap_fch: got %0d want 1", fch_o[0]); end
    checks++;
    if (capa_o[0] !== (CAP_EN ? 8'h55 : 8'h00) || capb_o[0] !== (CAP_EN ? 8'h54 : 8'h00)) begin
      errors++; $display("FAIL gap_cap: got %h/%h want %h/%h", capa_o[0], capb_o[0],
                         CAP_EN ? 8'h55 : 8'h00, CAP_EN ? 8'h54 : 8'h00);
    end
    step(1'b1, 16'h553C, 16'h553C, 1'b0);
    checks++; if (st_o[0] !== 2'b10) begin errors++; $display("FAIL fault_sticky: got %0d want 2", st_o[0]); end
  endtask

  task automatic test_saturate_clear();
    prime(16'h553C);
    for (int n = 0; n < 20; n++) step(1'b1, 16'h553C, 16'h553C ^ 16'(($urandom_range(1, 255)) << 8), 1'b0);
    checks++; if (err_o[0] !== 4'd15 || err_o[1] !== 4'd15) begin
      errors++; $display("FAIL err_saturate: got %0d/%0d want 15/15", err_o[0], err_o[1]); end
    step(1'b1, 16'h553C, 16'h543C, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (st_o[i] !== 2'b00 || err_o[i] !== 4'd0 || flt_o[i] !== 1'b0 || mis_o[i] !== 2'b00 || fch_o[i] !== 1'b0) begin
        errors++; $display("FAIL clear_prio[%0d]: got st=%0d err=%0d flt=%b mis=%b fch=%0d want all 0",
                           i, st_o[i], err_o[i], flt_o[i], mis_o[i], fch_o[i]);
      end
    end
  endtask

  task automatic test_both_channels();
    prime(16'h553C);
    step(1'b1, 16'h553C, 16'h543D, 1'b0);
    checks++; if (st_o[1] !== 2'b10 || fch_o[1] !== 1'b0) begin
      errors++; $display("FAIL both_fault: got st=%0d fch=%0d want 2/0", st_o[1], fch_o[1]); end
    checks++; if (mis_o[1] !== 2'b11) begin errors++; $display("FAIL both_mis: got %b want 11", mis_o[1]); end
    checks++;
    if (capa_o[1] !== (CAP_EN ? 8'h3C : 8'h00) || capb_o[1] !== (CAP_EN ? 8'h3D : 8'h00)) begin
      errors++; $display("FAIL both_cap: got %h/%h want %h/%h", capa_o[1], capb_o[1],
                         CAP_EN ? 8'h3C : 8'h00, CAP_EN ? 8'h3D : 8'h00);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    checks++; if (st_o[0] !== 2'b10) begin errors++; $display("FAIL pre_reset_fault: got %0d want 2", st_o[0]); end
    #2 rst_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (st_o[i] !== 2'b00 || flt_o[i] !== 1'b0 || err_o[i] !== 4'd0 || mis_o[i] !== 2'b00 ||
          fch_o[i] !== 1'b0 || capa_o[i] !== 8'h00 || capb_o[i] !== 8'h00) begin
        errors++; $display("FAIL async_reset[%0d]: got st=%0d flt=%b err=%0d mis=%b fch=%0d cap=%h/%h want all 0",
                           i, st_o[i], flt_o[i], err_o[i], mis_o[i], fch_o[i], capa_o[i], capb_o[i]);
      end
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 16'h553C, 16'h543C, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (st_o[i] !== 2'b00 || err_o[i] !== 4'd0 || mis_o[i] !== 2'b00) begin
          errors++; $display("FAIL warmup[%0d] cyc %0d: got st=%0d err=%0d mis=%b want 0/0/00", i, n, st_o[i], err_o[i], mis_o[i]);
        end
      end
    end
    step(1'b1, 16'h553C, 16'h543C, 1'b0);
    checks++; if (err_o[0] !== 4'd1 || st_o[0] !== 2'b01 || mis_o[0] !== 2'b10) begin
      errors++; $display("FAIL first_compare: got err=%0d st=%0d mis=%b want 1/1/10", err_o[0], st_o[0], mis_o[0]); end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        v, c;
    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom);
      b = hist[TDLY-1];
      if ($urandom_range(0, 2) == 0) b = b ^ 16'(1 << $urandom_range(0, 15));
      v = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 24) == 0);
      step(v, a, b, c);
      for (int i = 0; i < 2; i++) begin
        checks++; if (st_o[i] !== 2'(st_m[i])) begin errors++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d want %0d", i, n, st_o[i], st_m[i]); end
        checks++; if (flt_o[i] !== (st_m[i] == 2)) begin errors++; $display("FAIL rnd_fault[%0d] cyc %0d: got %b want %b", i, n, flt_o[i], st_m[i] == 2); end
        checks++; if (mis_o[i] !== mis_m) begin errors++; $display("FAIL rnd_mis[%0d] cyc %0d: got %b want %b", i, n, mis_o[i], mis_m); end
        checks++; if (err_o[i] !== 4'(err_m[i])) begin errors++; $display("FAIL rnd_err[%0d] cyc %0d: got %0d want %0d", i, n, err_o[i], err_m[i]); end
        checks++; if (fch_o[i] !== 1'(fch_m[i])) begin errors++; $display("FAIL rnd_fch[%0d] cyc %0d: got %0d want %0d", i, n, fch_o[i], fch_m[i]); end
        checks++; if (capa_o[i] !== capa_m[i] || capb_o[i] !== capb_m[i]) begin
          errors++; $display("FAIL rnd_cap[%0d] cyc %0d: got %h/%h want %h/%h", i, n, capa_o[i], capb_o[i], capa_m[i], capb_m[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_match_stream();
    test_suspect_recover();
    test_fault_gaps();
    test_saturate_clear();
    test_both_channels();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lockstep_checker.md
LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the bit width of one compared channel.
REQ-002 The block SHALL have parameter N, default 2, giving the number of compared channel pairs (N >= 1).
REQ-003 The block SHALL have parameter DLY, default 0, giving the cycles by which side A is delayed before compare (0..15).
REQ-004 The block SHALL have parameter THRESH, default 1, giving the consecutive mismatching compare cycles needed to declare a fault (1..255).
REQ-005 The block SHALL have parameter CW, default 8, giving the width of the error counter.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port a_i, input, N*W bits: side-A channels, channel k in bits [k*W +: W].
REQ-009 The block SHALL have port b_i, input, N*W bits: side-B channels, same packing as a_i.
REQ-010 The block SHALL have port valid_i, input, 1 bit: b_i holds a sample to compare this cycle.
REQ-011 The block SHALL have port clear_i, input, 1 bit: synchronous fault and statistics clear.
REQ-012 The block SHALL have port mismatch_o, output, N bits: per-channel result of the previous compare cycle.
REQ-013 The block SHALL have port state_o, output, 2 bits: OK=00, SUSPECT=01, FAULT=10.
REQ-014 The block SHALL have port fault_o, output, 1 bit: sticky fault flag, equal to (state_o == FAULT).
REQ-015 The block SHALL have port fault_ch_o, output, max(1,clog2(N)) bits: channel index latched on FAULT entry.
REQ-016 The block SHALL have port err_cnt_o, output, CW bits: saturating count of mismatching compare cycles.
REQ-017 The block SHALL have ports cap_a_o and cap_b_o, output, W bits each: captured values (see Configuration).

Function
REQ-018 Side A SHALL pass through a DLY-stage register line, so a valid cycle at t compares a_i(t-DLY) with b_i(t); DLY=0 means direct compare.
REQ-019 A compare cycle SHALL be a cycle with valid_i=1, clear_i=0 and the warm-up complete, meaning at least DLY cycles since reset release.
REQ-020 mismatch_o[k] SHALL be registered: it is 1 one cycle after a compare cycle where channel k differs, and 0 after a matching or non-compare cycle.
REQ-021 In OK, a compare cycle with any mismatch SHALL go to FAULT if THRESH=1, otherwise to SUSPECT with the run count set to 1.
REQ-022 In SUSPECT, a mismatching compare cycle SHALL increment the run count and go to FAULT when the count reaches THRESH; a matching compare cycle SHALL return to OK and zero the count; a non-compare cycle SHALL hold the state.
REQ-023 FAULT SHALL be sticky and left only via clear_i or reset.
REQ-024 On FAULT entry, fault_ch_o SHALL latch the lowest mismatching channel index of that compare cycle and hold it while in FAULT.
REQ-025 err_cnt_o SHALL increment on every mismatching compare cycle in any state and saturate at 2^CW-1 without wrapping.
REQ-026 clear_i=1 SHALL, on that edge, set state to OK and zero the run count, err_cnt_o, fault_ch_o, the captures and mismatch_o; that cycle's compare is discarded, and clear_i has priority over a simultaneous mismatch.
REQ-027 clear_i SHALL NOT flush the delay line.

Reset
REQ-028 Reset asserted (rst_i=0) SHALL immediately force state_o=00, fault_o=0, mismatch_o=0, err_cnt_o=0, fault_ch_o=0, cap_a_o=0, cap_b_o=0, the run count to 0, the delay line to 0 and the warm-up counter to 0, including mid-run or while in FAULT.
REQ-029 After rst_i deasserts, compares SHALL be suppressed for DLY cycles, with no compares while DLY is not yet satisfied.

Configuration
REQ-030 With macro LOCKSTEP_CAPTURE_EN defined, FAULT entry SHALL latch the delayed a and b values of channel fault_ch onto cap_a_o and cap_b_o and hold them until clear_i or reset.
REQ-031 Without LOCKSTEP_CAPTURE_EN, cap_a_o and cap_b_o SHALL be constant 0, and no capture registers SHALL exist.

Verification (N=2, W=8, DLY=2, THRESH=3, CW=4 unless noted)
REQ-032 Scenario: identical streams on both sides, valid every cycle for 50 cycles, with b_i equal to a_i delayed 2 -> state_o=00, err_cnt_o=0 and mismatch_o=00 throughout.
REQ-033 Scenario: channel 1 differs (A=0x55, B=0x54) for 2 compare cycles, then matches -> SUSPECT then back to OK, err_cnt_o=2, fault_o=0.
REQ-034 Scenario: channel 1 differs for 3 consecutive compare cycles, with valid_i=0 gaps in between -> FAULT after the third, fault_ch_o=1, and with the macro defined cap_a_o=0x55 and cap_b_o=0x54.
REQ-035 Scenario: 20 mismatching compare cycles with CW=4 -> err_cnt_o saturates at 15; then clear_i while a mismatch is present -> state OK, counts 0, fault_o=0 next cycle.
REQ-036 Scenario: both channels mismatch on the same cycle with THRESH=1 -> immediate FAULT with fault_ch_o=0, and mismatch_o=11 one cycle later.
REQ-037 Scenario: rst_i pulsed low while in FAULT -> all outputs 0 asynchronously; valid mismatching input in the first 2 cycles after release -> no count and no state change.
